// File: rtl/dmem_mmio.sv
// Data-side memory for the RV32I core: word RAM plus a 16-byte MMIO window
// holding a console TX FIFO, a status register and a free-running cycle counter.
module dmem_mmio #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  output logic [31:0] data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;

  // Address decode
  logic          ram_hit;
  logic          mmio_hit;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;

  assign ram_hit  = ({1'b0, addr} < RAM_BYTES);
  assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel  = addr[3:2];
  assign word_idx = addr[AW+1:2];

  // Data RAM: plain array with registered read-first port
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ram_q_reg;
  logic        ram_we;

  assign ram_we = wr && ram_hit;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[word_idx] <= wdata;
    end
    ram_q_reg <= mem[word_idx];
  end

  // TX FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic [31:0]   cycle_reg, cycle_next;

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic push;
  logic pop;
  logic ovf_set;
  logic ovf_clr;
  logic cycle_wr;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign tx_valid   = !fifo_empty;
  // Gated so the head reads as zero whenever the FIFO is empty, including right after reset.
  assign tx_data    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];

  assign pop      = tx_valid && tx_ready;
  assign push_req = wr && mmio_hit && (reg_sel == REG_TXDATA);
  // A pop on the same edge frees the slot, so a push to a full FIFO still lands.
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = wr && mmio_hit && (reg_sel == REG_STATUS) && wdata[2];
  assign cycle_wr = wr && mmio_hit && (reg_sel == REG_CYCLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= wdata[7:0];
    end
  end

  always_comb begin
    wr_ptr_next   = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next   = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    count_next    = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
    overflow_next = overflow_reg;
    if (ovf_clr) begin
      overflow_next = 1'b0;
    end
    if (ovf_set) begin
      overflow_next = 1'b1;
    end
    cycle_next = cycle_wr ? wdata : cycle_reg + 32'd1;
  end

  // MMIO read value for the current address; unmapped and write-only registers read 0
  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    if (mmio_hit) begin
      case (reg_sel)
        REG_STATUS: mmio_rd = {16'h0000, 8'(count_reg), 5'b00000, overflow_reg, fifo_full, fifo_empty};
        REG_CYCLE:  mmio_rd = cycle_reg;
        default:    mmio_rd = '0;
      endcase
    end
  end

  logic        sel_ram_reg;
  logic [31:0] mmio_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      cycle_reg    <= '0;
      sel_ram_reg  <= 1'b0;
      mmio_q_reg   <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      cycle_reg    <= cycle_next;
      sel_ram_reg  <= ram_hit;
      mmio_q_reg   <= mmio_rd;
    end
  end

  // The RAM output register carries no reset; the cleared select keeps data at zero during reset.
  assign data = sel_ram_reg ? ram_q_reg : mmio_q_reg;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: vector table, hand-written corner sequences
// and randomized traffic checked against a queue/array reference model.
module tb_dmem_mmio;
  localparam int unsigned MEM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
  localparam logic [31:0] A_TX  = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_ST  = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_CY  = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_RSV = MMIO_BASE + 32'hC;
  localparam logic [31:0] A_UNM = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  dmem_mmio #(
    .MEM_WORDS(MEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .addr(addr),
    .wdata(wdata),
    .wr(wr),
    .data(data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_q [$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cyc = '0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_data;
  logic        exp_known;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        w;
    logic        rdy;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_cyc = '0;
  endfunction

  // One clock edge of the reference model, from the rules: read old state, then update.
  function automatic void model_edge(input logic [31:0] a, input logic [31:0] wd,
                                     input logic w, input logic rdy);
    bit     is_ram  = (a < 32'(MEM_WORDS * 4));
    bit     is_mmio = ((a >> 4) == (MMIO_BASE >> 4));
    int     idx     = int'(a >> 2);
    int     r       = int'((a >> 2) & 32'h3);
    int     size0   = m_q.size();
    bit     popped  = (size0 > 0) && rdy;
    bit     set_ovf = 1'b0;
    exp_known = 1'b1;
    exp_data  = '0;
    if (is_ram) begin
      if (ref_mem.exists(idx)) exp_data = ref_mem[idx];
      else exp_known = 1'b0;
    end else if (is_mmio && r == 1) begin
      exp_data = {16'h0, 8'(size0), 5'h0, m_ovf, 1'(size0 == FIFO_DEPTH), 1'(size0 == 0)};
    end else if (is_mmio && r == 2) begin
      exp_data = m_cyc;
    end
    if (popped) void'(m_q.pop_front());
    if (w && is_mmio && r == 0) begin
      if (size0 < FIFO_DEPTH || popped) m_q.push_back(wd[7:0]);
      else set_ovf = 1'b1;
    end
    if (w && is_mmio && r == 1 && wd[2]) m_ovf = 1'b0;
    if (set_ovf) m_ovf = 1'b1;
    m_cyc = (w && is_mmio && r == 2) ? wd : m_cyc + 32'd1;
    if (w && is_ram) ref_mem[idx] = wd;
  endfunction

  // Drive one transaction, clock it, then compare every output with the model.
  task automatic do_cycle(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic rdy);
    addr = a;
    wdata = wd;
    wr = w;
    tx_ready = rdy;
    model_edge(a, wd, w, rdy);
    @(posedge clk);
    #1;
    $display("t=%0t addr=%h wdata=%h wr=%b rdy=%b -> data=%h tx_valid=%b tx_data=%h",
             $time, a, wd, w, rdy, data, tx_valid, tx_data);
    if (exp_known) check("data", data, exp_data);
    check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    check("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    // Reset state
    #23;
    check("reset_data", data, 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Counter starts at zero on the first edge after release
    do_cycle(A_CY, 32'h0, 1'b0, 1'b0);
    check("cycle_edge0", data, 32'd0);
    do_cycle(A_CY, 32'h0, 1'b0, 1'b0);
    check("cycle_edge1", data, 32'd1);

    vecs = '{
      '{32'h10,        32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h10,        32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF},
      '{32'h13,        32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF},
      '{A_UNM,         32'h0,         1'b0, 1'b0, 1'b1, 32'h0},
      '{32'h20,        32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h20,        32'h2222_2222, 1'b1, 1'b0, 1'b1, 32'h1111_1111},
      '{32'h20,        32'h0,         1'b0, 1'b0, 1'b1, 32'h2222_2222},
      '{32'hFFC,       32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h1000,      32'h5555_AAAA, 1'b1, 1'b0, 1'b1, 32'h0},
      '{32'hFFE,       32'h0,         1'b0, 1'b0, 1'b1, 32'hCAFE_F00D},
      '{32'h1000,      32'h0,         1'b0, 1'b0, 1'b1, 32'h0},
      '{A_RSV,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0},
      '{A_RSV,         32'h0,         1'b0, 1'b0, 1'b1, 32'h0},
      '{A_TX,          32'h0,         1'b0, 1'b0, 1'b1, 32'h0},
      '{A_ST,          32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0001},
      '{MMIO_BASE + 32'h10, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0}
    };
    foreach (vecs[i]) begin
      do_cycle(vecs[i].a, vecs[i].wd, vecs[i].w, vecs[i].rdy);
      if (vecs[i].chk) check($sformatf("vec%0d", i), data, vecs[i].exp);
    end

    // Fill past capacity with the consumer stalled
    for (int i = 0; i < 9; i++) do_cycle(A_TX, 32'h41 + 32'(i), 1'b1, 1'b0);
    do_cycle(A_ST, 32'h0, 1'b0, 1'b0);
    check("status_full_ovf", data, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      check("drain_byte", 32'(tx_data), 32'h41 + 32'(i));
      do_cycle(A_UNM, 32'h0, 1'b0, 1'b1);
    end
    check("drained_valid", 32'(tx_valid), 32'h0);
    do_cycle(A_ST, 32'h4, 1'b1, 1'b0);
    do_cycle(A_ST, 32'h0, 1'b0, 1'b0);
    check("status_cleared", data, 32'h0000_0001);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) do_cycle(A_TX, 32'h61 + 32'(i), 1'b1, 1'b0);
    do_cycle(A_TX, 32'h5A, 1'b1, 1'b1);
    do_cycle(A_ST, 32'h0, 1'b0, 1'b0);
    check("status_pushpop", data, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      check("pushpop_byte", 32'(tx_data), (i == 7) ? 32'h5A : 32'h62 + 32'(i));
      do_cycle(A_UNM, 32'h0, 1'b0, 1'b1);
    end
    check("pushpop_empty", 32'(tx_valid), 32'h0);

    // Counter load and wrap
    do_cycle(A_CY, 32'hFFFF_FFFE, 1'b1, 1'b0);
    do_cycle(A_UNM, 32'h0, 1'b0, 1'b0);
    do_cycle(A_CY, 32'h0, 1'b0, 1'b0);
    check("cycle_max", data, 32'hFFFF_FFFF);
    do_cycle(A_CY, 32'h0, 1'b0, 1'b0);
    check("cycle_wrap", data, 32'h0000_0000);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] wd;
      wd = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'($urandom_range(0, 63));
        1: a = 32'hFFC + 32'($urandom_range(0, 3));
        2: a = MMIO_BASE + 32'($urandom_range(0, 15));
        3: a = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : MMIO_BASE + 32'h10;
        4: a = A_TX;
        default: a = A_ST;
      endcase
      do_cycle(a, wd, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with bytes queued and a nonzero counter
    for (int i = 0; i < 10; i++) do_cycle(A_UNM, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(A_TX, 32'h30 + 32'(i), 1'b1, 1'b0);
    do_cycle(A_CY, 32'd500, 1'b1, 1'b0);
    do_cycle(A_CY, 32'h0, 1'b0, 1'b0);
    check("pre_reset_cycle", data, 32'd500);
    wr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    check("async_data", data, 32'h0);
    check("async_tx_data", 32'(tx_data), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle(A_CY, 32'h0, 1'b0, 1'b0);
    check("cycle_restart", data, 32'd0);
    do_cycle(A_ST, 32'h0, 1'b0, 1'b0);
    check("status_after_reset", data, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem sitting directly downstream of the RV32I core's data port (addr/wdata/wr/data).
- Provides a word-organised synchronous data RAM and a small MMIO window: console TX FIFO with byte-stream output, status register and free-running cycle counter.
- All reads are side-effect-free, because the core performs a read before every store and then writes a merged word.

Parameters:
- MEM_WORDS, 1024: data RAM depth in 32-bit words; RAM region is byte addresses 0 .. MEM_WORDS*4-1.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, at least 2.
- MMIO_BASE, 32'h8000_0000: base of the 16-byte MMIO window; bits [3:0] are zero.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- addr, input, 32: byte address from the core; held stable by the core for the whole access.
- wdata, input, 32: write data, valid when wr=1.
- wr, input, 1: single-cycle write strobe.
- data, output, 32: registered read data.
- tx_valid, output, 1: FIFO head byte available.
- tx_data, output, 8: FIFO head byte.
- tx_ready, input, 1: downstream consumer accepts the head byte this cycle.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, data=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0, cycle counter=0. RAM contents are not reset.
- Address decode, evaluated every cycle on addr:
  - RAM if addr < MEM_WORDS*4; word index = addr[clog2(MEM_WORDS)+1:2].
  - MMIO if addr[31:4]==MMIO_BASE[31:4]; register = addr[3:2].
  - Otherwise unmapped.
  - addr[1:0] is ignored everywhere; the core does its own byte/half merging.
- Read path, 1-cycle latency: every posedge, data <= decoded read value of the current addr. A value on addr at edge N appears on data after edge N+1 (the core samples two edges after issuing addr, so latency ≤2 is sufficient).
  - Unmapped reads return 0.
- RAM write: when wr=1 and addr is in RAM, mem[word] <= wdata at that edge.
  - Same-cycle read of the written word returns the old value (read-first).
  - Unmapped writes are ignored.
- MMIO registers:
  - 0x0 TXDATA: write pushes wdata[7:0] into FIFO. If FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set (sticky). Reads return 0.
  - 0x4 STATUS: reads return the following fields:
    - bit0 empty, bit1 full, bit2 overflow.
    - bits[15:8] occupancy count, zero-extended.
    - remaining bits 0.
    - A write with wdata[2]=1 clears overflow; other bits are ignored.
  - 0x8 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0. A read returns the value current at the sampling edge. A write loads wdata, and the counter continues from wdata+1 on the following edge.
  - 0xC: reserved; reads return 0, writes are ignored.
- TX FIFO:
  - Circular buffer with read/write pointers and an occupancy counter of width clog2(FIFO_DEPTH+1).
  - tx_valid = !empty; tx_data = head entry, combinational from storage.
  - Pop occurs when tx_valid && tx_ready.
  - Push and pop on the same edge: both take effect and count is unchanged. When full, that push is accepted with no overflow.
  - Push to an empty FIFO: tx_valid rises after that edge, never in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- STATUS clear and a new overflow event on the same edge: set wins.
- CYCLE write and increment on the same edge: the write wins.
- Reset asserted mid-stream: FIFO contents are discarded immediately (tx_valid=0 asynchronously) and the counter clears.
- Each mapped/unmapped region decodes exactly one target; there are no aliases inside RAM.

Test Plan:
- RAM round trip: write 0xDEAD_BEEF to addr 0x10 (wr pulse), then hold addr 0x10 -> data=0xDEAD_BEEF one edge later. Hold addr 0x13 -> same word. Addr 0x0010_0000 (unmapped) -> data=0.
- Read-first: wr=1 to 0x20 (old value 0x1111_1111, wdata 0x2222_2222) -> data on the next edge is 0x1111_1111; the following edge gives 0x2222_2222.
- FIFO fill/overflow: tx_ready=0, push bytes 0x41..0x49 (9 writes, DEPTH 8) -> STATUS reads 0x0000_0806 (full, overflow, count 8). Then tx_ready=1 -> 0x41..0x48 emitted in order, then tx_valid=0. Then write STATUS 0x4 -> STATUS=0x0000_0001.
- Full with simultaneous push/pop: FIFO full, tx_ready=1, push 0x5A on the same edge -> count stays 8, overflow stays 0, and 0x5A is emitted last.
- CYCLE: after reset, read CYCLE at a known edge k -> value k. Write 0xFFFF_FFFE -> reads 0xFFFF_FFFF then 0x0000_0000 (wrap).
- Async reset mid-operation: 3 bytes queued and CYCLE=500, assert rst_n=0 between edges -> tx_valid=0 and data=0 immediately. After release, STATUS=0x0000_0001 and CYCLE restarts from 0.
